// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage -- execute stage of the 5-stage pipeline.
//
// Contains the ALU, ALU-control decode, RegDst mux, branch-target adder, an
// iterative shift-add multiplier and the EX/MEM pipeline latch.
//
// Ports:
//   clk, rst_n         pipeline clock (rising edge), async active-low reset
//   flush              squash the instruction currently in EX
//   NPC                PC+4 of the instruction in EX
//   ReadData1/2        rs / rt operands (ReadData2 is also store data)
//   SignExtImm         sign-extended immediate, [5:0] carries funct
//   Rt, Rd             destination register candidates
//   WBControl          {RegWrite, MemtoReg}, passed through
//   MControl           {Branch, MemRead, MemWrite}, passed through
//   EXControl          {RegDst, ALUOp[1:0], ALUSrc}
//   stall              holds PC, IF/ID and ID/EX while a multiply runs
//   *_out              EX/MEM latch contents
// ----------------------------------------------------------------------------
module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] NPC,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] SignExtImm,
  input  logic [4:0]       Rt,
  input  logic [4:0]       Rd,
  input  logic [1:0]       WBControl,
  input  logic [2:0]       MControl,
  input  logic [3:0]       EXControl,
  output logic             stall,
  output logic [WIDTH-1:0] ALUResult_out,
  output logic [WIDTH-1:0] WriteData_out,
  output logic [4:0]       WriteReg_out,
  output logic [1:0]       WBControl_out,
  output logic             Branch_out,
  output logic             MemRead_out,
  output logic             MemWrite_out,
  output logic             Zero_out,
  output logic [WIDTH-1:0] BranchTarget_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  // The last BUSY iteration happens when the counter is about to reach WIDTH-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 2);

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LOAD_BUBBLE = 2'd0,
    LOAD_ALU    = 2'd1,
    LOAD_MUL    = 2'd2
  } load_sel_t;

  state_t    state_r;
  state_t    state_nxt_s;
  load_sel_t load_sel_s;
  logic      stall_s;

  logic             reg_dst_s;
  logic [1:0]       alu_op_s;
  logic             alu_src_s;
  logic [5:0]       funct_s;
  logic [WIDTH-1:0] op_b_s;
  logic [4:0]       write_reg_s;
  logic             is_mul_s;
  logic [WIDTH-1:0] alu_result_s;
  logic [WIDTH-1:0] branch_target_s;
  logic [WIDTH-1:0] mul_final_s;

  logic [WIDTH-1:0] mul_a_r;
  logic [WIDTH-1:0] mul_b_r;
  logic [WIDTH-1:0] mul_acc_r;
  logic [CNT_W-1:0] mul_cnt_r;

  logic [WIDTH-1:0] nxt_result_s;
  logic [WIDTH-1:0] nxt_wdata_s;
  logic [4:0]       nxt_wreg_s;
  logic [1:0]       nxt_wb_s;
  logic [2:0]       nxt_m_s;
  logic             nxt_zero_s;
  logic [WIDTH-1:0] nxt_bt_s;

  assign reg_dst_s   = EXControl[3];
  assign alu_op_s    = EXControl[2:1];
  assign alu_src_s   = EXControl[0];
  assign funct_s     = SignExtImm[5:0];
  assign op_b_s      = alu_src_s ? SignExtImm : ReadData2;
  assign write_reg_s = reg_dst_s ? Rd : Rt;
  assign is_mul_s    = (alu_op_s == 2'b10) && (funct_s == FUNCT_MUL);
  assign branch_target_s = NPC + {SignExtImm[WIDTH-3:0], 2'b00};

  // The final shift-add step is folded into the DONE-cycle capture, so BUSY
  // only needs WIDTH-1 iterations while the product is still complete.
  assign mul_final_s = mul_acc_r + (mul_b_r[0] ? mul_a_r : {WIDTH{1'b0}});

  // Stall is never asserted while the pipeline is held in reset.
  assign stall = stall_s & rst_n;

  // ALU operation decode and single-cycle result.
  always_comb begin
    alu_result_s = {WIDTH{1'b0}};
    case (alu_op_s)
      2'b00: alu_result_s = ReadData1 + op_b_s;
      2'b01: alu_result_s = ReadData1 - op_b_s;
      2'b10: begin
        case (funct_s)
          FUNCT_ADD: alu_result_s = ReadData1 + op_b_s;
          FUNCT_SUB: alu_result_s = ReadData1 - op_b_s;
          FUNCT_AND: alu_result_s = ReadData1 & op_b_s;
          FUNCT_OR:  alu_result_s = ReadData1 | op_b_s;
          FUNCT_SLT: alu_result_s = {{(WIDTH-1){1'b0}},
                                     ($signed(ReadData1) < $signed(op_b_s))};
          default:   alu_result_s = {WIDTH{1'b0}};
        endcase
      end
      default: alu_result_s = {WIDTH{1'b0}};
    endcase
  end

  // Multiplier FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Multiplier FSM next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (is_mul_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (mul_cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Multiplier FSM outputs: stall and what the latch captures at the next edge.
  always_comb begin
    stall_s    = 1'b0;
    load_sel_s = LOAD_BUBBLE;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          stall_s    = 1'b0;
          load_sel_s = LOAD_BUBBLE;
        end else if (is_mul_s) begin
          stall_s    = 1'b1;
          load_sel_s = LOAD_BUBBLE;
        end else begin
          stall_s    = 1'b0;
          load_sel_s = LOAD_ALU;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          stall_s    = 1'b0;
          load_sel_s = LOAD_BUBBLE;
        end else begin
          stall_s    = 1'b1;
          load_sel_s = LOAD_BUBBLE;
        end
      end
      ST_DONE: begin
        if (flush) begin
          stall_s    = 1'b0;
          load_sel_s = LOAD_BUBBLE;
        end else begin
          stall_s    = 1'b0;
          load_sel_s = LOAD_MUL;
        end
      end
      default: begin
        stall_s    = 1'b0;
        load_sel_s = LOAD_BUBBLE;
      end
    endcase
  end

  // Shift-add multiplier datapath: operand capture in IDLE, iterate in BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_r   <= {WIDTH{1'b0}};
      mul_b_r   <= {WIDTH{1'b0}};
      mul_acc_r <= {WIDTH{1'b0}};
      mul_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!flush && is_mul_s) begin
            mul_a_r   <= ReadData1;
            mul_b_r   <= op_b_s;
            mul_acc_r <= {WIDTH{1'b0}};
            mul_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_BUSY: begin
          if (!flush) begin
            mul_acc_r <= mul_acc_r + (mul_b_r[0] ? mul_a_r : {WIDTH{1'b0}});
            mul_a_r   <= {mul_a_r[WIDTH-2:0], 1'b0};
            mul_b_r   <= {1'b0, mul_b_r[WIDTH-1:1]};
            mul_cnt_r <= mul_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          mul_cnt_r <= mul_cnt_r;
        end
      endcase
    end
  end

  // Next EX/MEM latch contents; a bubble zeroes every field.
  always_comb begin
    nxt_result_s = {WIDTH{1'b0}};
    nxt_wdata_s  = {WIDTH{1'b0}};
    nxt_wreg_s   = 5'd0;
    nxt_wb_s     = 2'b00;
    nxt_m_s      = 3'b000;
    nxt_zero_s   = 1'b0;
    nxt_bt_s     = {WIDTH{1'b0}};
    case (load_sel_s)
      LOAD_ALU: begin
        nxt_result_s = alu_result_s;
        nxt_wdata_s  = ReadData2;
        nxt_wreg_s   = write_reg_s;
        nxt_wb_s     = WBControl;
        nxt_m_s      = MControl;
        nxt_zero_s   = (alu_result_s == {WIDTH{1'b0}});
        nxt_bt_s     = branch_target_s;
      end
      LOAD_MUL: begin
        nxt_result_s = mul_final_s;
        nxt_wdata_s  = ReadData2;
        nxt_wreg_s   = write_reg_s;
        nxt_wb_s     = WBControl;
        nxt_m_s      = MControl;
        nxt_zero_s   = (mul_final_s == {WIDTH{1'b0}});
        nxt_bt_s     = branch_target_s;
      end
      default: begin
        nxt_result_s = {WIDTH{1'b0}};
        nxt_zero_s   = 1'b0;
      end
    endcase
  end

  // EX/MEM pipeline latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResult_out    <= {WIDTH{1'b0}};
      WriteData_out    <= {WIDTH{1'b0}};
      WriteReg_out     <= 5'd0;
      WBControl_out    <= 2'b00;
      Branch_out       <= 1'b0;
      MemRead_out      <= 1'b0;
      MemWrite_out     <= 1'b0;
      Zero_out         <= 1'b0;
      BranchTarget_out <= {WIDTH{1'b0}};
    end else begin
      ALUResult_out    <= nxt_result_s;
      WriteData_out    <= nxt_wdata_s;
      WriteReg_out     <= nxt_wreg_s;
      WBControl_out    <= nxt_wb_s;
      Branch_out       <= nxt_m_s[2];
      MemRead_out      <= nxt_m_s[1];
      MemWrite_out     <= nxt_m_s[0];
      Zero_out         <= nxt_zero_s;
      BranchTarget_out <= nxt_bt_s;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] NPC, ReadData1, ReadData2, SignExtImm;
  logic [4:0]  Rt, Rd;
  logic [1:0]  WBControl;
  logic [2:0]  MControl;
  logic [3:0]  EXControl;
  logic        stall;
  logic [31:0] ALUResult_out, WriteData_out, BranchTarget_out;
  logic [4:0]  WriteReg_out;
  logic [1:0]  WBControl_out;
  logic        Branch_out, MemRead_out, MemWrite_out, Zero_out;

  int checks;
  int failures;

  ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .NPC(NPC), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .SignExtImm(SignExtImm), .Rt(Rt), .Rd(Rd),
    .WBControl(WBControl), .MControl(MControl), .EXControl(EXControl),
    .stall(stall), .ALUResult_out(ALUResult_out),
    .WriteData_out(WriteData_out), .WriteReg_out(WriteReg_out),
    .WBControl_out(WBControl_out), .Branch_out(Branch_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
    .Zero_out(Zero_out), .BranchTarget_out(BranchTarget_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] npc, rd1, rd2, imm;
    logic [4:0]  rt, rd;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] exp_res;
    logic [4:0]  exp_wr;
    logic        exp_zero;
    logic [31:0] exp_bt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_latch(input string tag, input logic [31:0] res, input logic [31:0] wd,
                             input logic [4:0] wr, input logic [1:0] wb, input logic [2:0] m,
                             input logic z, input logic [31:0] bt);
    chk({tag, ".ALUResult"}, ALUResult_out, res);
    chk({tag, ".WriteData"}, WriteData_out, wd);
    chk({tag, ".WriteReg"}, {27'd0, WriteReg_out}, {27'd0, wr});
    chk({tag, ".WBControl"}, {30'd0, WBControl_out}, {30'd0, wb});
    chk({tag, ".MControl"}, {29'd0, Branch_out, MemRead_out, MemWrite_out}, {29'd0, m});
    chk({tag, ".Zero"}, {31'd0, Zero_out}, {31'd0, z});
    chk({tag, ".BranchTarget"}, BranchTarget_out, bt);
  endtask

  task automatic check_bubble(input string tag);
    check_latch(tag, 32'd0, 32'd0, 5'd0, 2'b00, 3'b000, 1'b0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [31:0] npc, rd1, rd2, imm, input logic [4:0] rt, rd,
                       input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex);
    NPC = npc; ReadData1 = rd1; ReadData2 = rd2; SignExtImm = imm;
    Rt = rt; Rd = rd; WBControl = wb; MControl = m; EXControl = ex;
  endtask

  task automatic add_vec(input logic [31:0] npc, rd1, rd2, imm, input logic [4:0] rt, rd,
                         input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                         input logic [31:0] exp_res, input logic [4:0] exp_wr,
                         input logic exp_zero, input logic [31:0] exp_bt);
    vec_t v;
    v.npc = npc; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.rt = rt; v.rd = rd;
    v.wb = wb; v.m = m; v.ex = ex; v.exp_res = exp_res; v.exp_wr = exp_wr;
    v.exp_zero = exp_zero; v.exp_bt = exp_bt;
    vq.push_back(v);
  endtask

  // Reference ALU written straight from the operation table.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic [5:0] f);
    logic [31:0] r;
    r = 32'd0;
    if (op == 2'd0) r = a + b;
    else if (op == 2'd1) r = a - b;
    else if (op == 2'd2) begin
      if (f == 6'h20) r = a + b;
      else if (f == 6'h22) r = a - b;
      else if (f == 6'h24) r = a & b;
      else if (f == 6'h25) r = a | b;
      else if (f == 6'h2A) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      else if (f == 6'h18) r = a * b;
      else r = 32'd0;
    end
    return r;
  endfunction

  // Issue a mul, count stall cycles, check bubbles, then the product.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    int n;
    logic [31:0] prod;
    prod = a * b;
    apply(32'h1000, a, b, 32'h18, rd ^ 5'd1, rd, 2'b10, 3'b000, 4'b1100);
    #1;
    chk({tag, ".stall_first"}, {31'd0, stall}, 32'd1);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      step();
      chk({tag, ".bubble"}, {27'd0, WBControl_out, Branch_out, MemRead_out, MemWrite_out}, 32'd0);
    end
    chk({tag, ".stall_cycles"}, n, 32'd32);
    step();
    check_latch(tag, prod, b, rd, 2'b10, 3'b000, prod == 32'd0, 32'h1060);
  endtask

  initial begin
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] r, a, b, imm, npc, bop, exp_res;
    logic        alusrc, regdst, fl;
    logic [4:0]  rt, rd;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [5:0]  functs[6];
    checks = 0;
    failures = 0;
    functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
    functs[3] = 6'h25; functs[4] = 6'h2A; functs[5] = 6'h3F;

    // ---- reset state ----
    rst_n = 1'b0;
    flush = 1'b0;
    apply(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00, 3'b000, 4'b0000);
    #2;
    check_bubble("reset");
    chk("reset.stall", {31'd0, stall}, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // ---- directed single-cycle table ----
    add_vec(32'h0,   32'd5, 32'd7, 32'h20, 5'd3, 5'd9, 2'b10, 3'b000, 4'b1100, 32'd12, 5'd9, 1'b0, 32'h80);
    add_vec(32'h10,  32'h100, 32'h55, 32'hFFFFFFFC, 5'd6, 5'd1, 2'b11, 3'b010, 4'b0001, 32'hFC, 5'd6, 1'b0, 32'h0);
    add_vec(32'h40,  32'd3, 32'd3, 32'd4, 5'd2, 5'd5, 2'b00, 3'b100, 4'b0010, 32'd0, 5'd2, 1'b1, 32'h50);
    add_vec(32'h0,   32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd8, 2'b10, 3'b000, 4'b1100, 32'd1, 5'd8, 1'b0, 32'hA8);
    add_vec(32'h0,   32'd1, 32'hFFFFFFFF, 32'h2A, 5'd1, 5'd8, 2'b10, 3'b000, 4'b1100, 32'd0, 5'd8, 1'b1, 32'hA8);
    add_vec(32'h4,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h24, 5'd1, 5'd10, 2'b10, 3'b000, 4'b1100, 32'h00F000F0, 5'd10, 1'b0, 32'h94);
    add_vec(32'h0,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h25, 5'd1, 5'd11, 2'b10, 3'b000, 4'b1100, 32'hFFF0FFF0, 5'd11, 1'b0, 32'h94);
    add_vec(32'h0,   32'd5, 32'd7, 32'h22, 5'd1, 5'd12, 2'b10, 3'b000, 4'b1100, 32'hFFFFFFFE, 5'd12, 1'b0, 32'h88);
    add_vec(32'h0,   32'd5, 32'd7, 32'h3F, 5'd1, 5'd13, 2'b10, 3'b000, 4'b1100, 32'd0, 5'd13, 1'b1, 32'hFC);
    add_vec(32'h200, 32'd5, 32'd7, 32'h0, 5'd14, 5'd15, 2'b01, 3'b001, 4'b0110, 32'd0, 5'd14, 1'b1, 32'h200);
    add_vec(32'h100, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd16, 5'd17, 2'b10, 3'b001, 4'b0000, 32'd0, 5'd16, 1'b1, 32'h100);
    add_vec(32'h0,   32'd10, 32'd99, 32'hFFFFFFFF, 5'd3, 5'd4, 2'b00, 3'b001, 4'b0011, 32'd11, 5'd3, 1'b0, 32'hFFFFFFFC);

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].npc, vq[i].rd1, vq[i].rd2, vq[i].imm, vq[i].rt, vq[i].rd,
            vq[i].wb, vq[i].m, vq[i].ex);
      #1;
      chk($sformatf("vec%0d.stall", i), {31'd0, stall}, 32'd0);
      step();
      check_latch($sformatf("vec%0d", i), vq[i].exp_res, vq[i].rd2, vq[i].exp_wr,
                  vq[i].wb, vq[i].m, vq[i].exp_zero, vq[i].exp_bt);
    end

    // ---- multiplies, including back-to-back ----
    run_mul("mul7x6", 32'd7, 32'd6, 5'd4);
    run_mul("mulmax2", 32'hFFFFFFFF, 32'd2, 5'd7);

    // ---- flush mid-multiply ----
    apply(32'h1000, 32'd9, 32'd9, 32'h18, 5'd2, 5'd3, 2'b10, 3'b000, 4'b1100);
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1;
    #1;
    chk("flush.stall_drop", {31'd0, stall}, 32'd0);
    step();
    check_bubble("flush");
    flush = 1'b0;
    apply(32'h8, 32'd20, 32'd22, 32'd1, 5'd5, 5'd6, 2'b10, 3'b000, 4'b0000);
    #1;
    chk("post_flush.stall", {31'd0, stall}, 32'd0);
    step();
    check_latch("post_flush", 32'd42, 32'd22, 5'd5, 2'b10, 3'b000, 1'b0, 32'hC);
    run_mul("mul_after_flush", 32'd3, 32'd5, 5'd9);

    // ---- flush together with a new mul in IDLE ----
    apply(32'h1000, 32'd4, 32'd4, 32'h18, 5'd2, 5'd3, 2'b10, 3'b000, 4'b1100);
    flush = 1'b1;
    #1;
    chk("flush_idle.stall", {31'd0, stall}, 32'd0);
    step();
    check_bubble("flush_idle");
    flush = 1'b0;
    apply(32'h0, 32'd1, 32'd2, 32'd0, 5'd7, 5'd8, 2'b10, 3'b000, 4'b0000);
    #1;
    chk("flush_idle.no_start", {31'd0, stall}, 32'd0);
    step();
    chk("flush_idle.next", ALUResult_out, 32'd3);

    // ---- reset mid-multiply ----
    apply(32'h1000, 32'd123, 32'd456, 32'h18, 5'd2, 5'd3, 2'b10, 3'b000, 4'b1100);
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid.stall", {31'd0, stall}, 32'd0);
    check_bubble("rst_mid");
    step();
    rst_n = 1'b1;
    run_mul("mul_after_rst", 32'd123, 32'd456, 5'd11);

    // ---- randomized single-cycle ops against the reference model ----
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      f = functs[$urandom_range(0, 5)];
      r = $urandom();
      imm = {r[31:6], f};
      a = $urandom();
      b = $urandom();
      if (i % 5 == 0) b = a;
      npc = $urandom();
      alusrc = 1'($urandom_range(0, 1));
      regdst = 1'($urandom_range(0, 1));
      rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      wb = 2'($urandom_range(0, 3));
      m = 3'($urandom_range(0, 7));
      fl = ($urandom_range(0, 7) == 0);
      apply(npc, a, b, imm, rt, rd, wb, m, {regdst, op, alusrc});
      flush = fl;
      #1;
      step();
      if (fl) begin
        check_bubble($sformatf("rnd%0d_flush", i));
      end else begin
        bop = alusrc ? imm : b;
        exp_res = ref_alu(a, bop, op, f);
        check_latch($sformatf("rnd%0d", i), exp_res, b, regdst ? rd : rt, wb, m,
                    exp_res == 32'd0, npc + imm * 32'd4);
      end
      flush = 1'b0;
    end

    // ---- randomized multiplies ----
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      b = (i % 2 == 0) ? 32'($urandom_range(0, 1000)) : $urandom();
      run_mul($sformatf("rndmul%0d", i), a, b, 5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
